// File: rtl/ov5640_cfg_seq.sv
// OV5640 register-table sequencer: walks a ROM of {reg_addr, value} entries and issues SCCB writes.
// Entries with reg_addr 16'hFFFF are delay entries lasting value*DELAY_UNIT clocks.
module ov5640_cfg_seq #(
  parameter logic [19:0] INIT_DELAY = 20'd1_000_000,
  parameter logic [7:0]  REG_NUM    = 8'd250,
  parameter logic [6:0]  SLAVE_ADDR = 7'h3C,
  parameter logic [1:0]  RETRY_MAX  = 2'd3,
  parameter logic [15:0] DELAY_UNIT = 16'd50_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [23:0] rom_data,
  output logic        sccb_req,
  output logic [6:0]  sccb_dev_addr,
  output logic [15:0] sccb_reg_addr,
  output logic [7:0]  sccb_wdata,
  input  logic        sccb_done,
  input  logic        sccb_nack,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [7:0]  err_index
);

  typedef enum logic [2:0] {PWRUP, FETCH, LATCH, ISSUE, DELAY, NEXT, DONE, ERROR} state_t;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] dly_tgt_q, dly_tgt_d;
  logic [7:0]  index_q, index_d;
  logic [1:0]  retry_q, retry_d;
  logic        req_q, req_d;
  logic [15:0] reg_addr_q, reg_addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [7:0]  err_index_q, err_index_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dly_tgt_d   = dly_tgt_q;
    index_d     = index_q;
    retry_d     = retry_q;
    req_d       = req_q;
    reg_addr_d  = reg_addr_q;
    wdata_d     = wdata_q;
    err_index_d = err_index_q;
    case (state_q)
      PWRUP: begin
        if (cnt_q + 24'd1 >= {4'd0, INIT_DELAY}) begin
          cnt_d   = 24'd0;
          index_d = 8'd0;
          state_d = (REG_NUM == 8'd0) ? DONE : FETCH;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        if (rom_data[23:8] == 16'hFFFF) begin
          dly_tgt_d = {16'd0, rom_data[7:0]} * {8'd0, DELAY_UNIT};
          cnt_d     = 24'd0;
          state_d   = DELAY;
        end else begin
          reg_addr_d = rom_data[23:8];
          wdata_d    = rom_data[7:0];
          req_d      = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // req low inside ISSUE is the one-cycle gap before a retry; completions there are ignored
        if (!req_q) begin
          req_d = 1'b1;
        end else if (sccb_done) begin
          req_d = 1'b0;
          if (!sccb_nack) begin
            retry_d = 2'd0;
            state_d = NEXT;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 2'd1;
          end else begin
            err_index_d = index_q;
            state_d     = ERROR;
          end
        end
      end
      DELAY: begin
        if (cnt_q + 24'd1 >= dly_tgt_q) state_d = NEXT;
        else                            cnt_d   = cnt_q + 24'd1;
      end
      NEXT: begin
        if (index_q == REG_NUM - 8'd1) begin
          state_d = DONE;
        end else begin
          index_d = index_q + 8'd1;
          state_d = FETCH;
        end
      end
      DONE, ERROR: begin
        if (start) begin
          index_d     = 8'd0;
          retry_d     = 2'd0;
          err_index_d = 8'd0;
          state_d     = FETCH;
        end
      end
      default: state_d = PWRUP;
    endcase
    busy_d  = !(state_d == DONE || state_d == ERROR);
    done_d  = (state_d == DONE);
    error_d = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWRUP;
      cnt_q       <= 24'd0;
      dly_tgt_q   <= 24'd0;
      index_q     <= 8'd0;
      retry_q     <= 2'd0;
      req_q       <= 1'b0;
      reg_addr_q  <= 16'd0;
      wdata_q     <= 8'd0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dly_tgt_q   <= dly_tgt_d;
      index_q     <= index_d;
      retry_q     <= retry_d;
      req_q       <= req_d;
      reg_addr_q  <= reg_addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
    end
  end

  assign rom_addr      = index_q;
  assign sccb_req      = req_q;
  assign sccb_dev_addr = SLAVE_ADDR;
  assign sccb_reg_addr = reg_addr_q;
  assign sccb_wdata    = wdata_q;
  assign cfg_busy      = busy_q;
  assign cfg_done      = done_q;
  assign cfg_error     = error_q;
  assign err_index     = err_index_q;

endmodule
